instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
- Upstream program-load stage for the MIPS core.
- Receives a byte stream from the UART receiver and assembles the bytes MSB-first into 32-bit instruction words.
- Drives the core's instruction-memory load interface: instruction, address and loading.
- Holds the fetch stage in load mode until a halt word is written. It then releases the core to run.

Parameters:
- DATA_WIDTH, 32, instruction/address width (fixed 4 bytes per word).
- BYTE_WIDTH, 8, UART byte width.
- MEM_DEPTH, 256, instruction memory capacity in words.
- ADDR_STEP, 4, address increment per written word (byte addressing).
- HALT_WORD, 32'hFFFF_FFFF, end-of-program instruction.
- CMD_LOAD, 8'h4C, command byte ('L') that starts a load.

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  BYTE_WIDTH  received UART byte
- i_rx_done  in  1  one-cycle strobe; i_rx_data valid this cycle
- o_instruccion  out  DATA_WIDTH  assembled word to instruction memory
- o_address  out  DATA_WIDTH  byte address for o_instruccion
- o_wr_en  out  1  one-cycle write strobe for o_instruccion/o_address
- o_loading  out  1  level; high while in LOAD (fetch stalled, memory owned by loader)
- o_done  out  1  level; high in DONE (program loaded, core may run)
- o_error  out  1  level; high in OVERFLOW
- o_word_count  out  clog2(MEM_DEPTH)+1  words written in the current load, halt word included

Behaviour:
- Single clock domain. Reset is synchronous and active-high; on i_reset every register clears on the next i_clock edge.
- Reset values: state=IDLE; o_instruccion=0; o_address=0; o_wr_en=0; o_loading=0; o_done=0; o_error=0; o_word_count=0; byte counter=0; shift register=0.
- FSM states: IDLE, LOAD, DONE, OVERFLOW.
- IDLE:
  - i_rx_done with i_rx_data==CMD_LOAD -> LOAD. On the same edge, clear the address counter, o_word_count and the byte counter.
  - Any other byte is ignored.
- LOAD:
  - o_loading=1.
  - Each i_rx_done shifts the byte in: shift = {shift[23:0], byte}. The first byte becomes bits [31:24].
  - Bytes are accepted only on i_rx_done cycles; gaps of any length are allowed.
  - Command bytes have no special meaning inside LOAD; 0x4C is data.
  - On the edge that samples the 4th byte:
    - o_instruccion is registered with the assembled word.
    - o_address is registered with the current address counter.
    - o_wr_en=1 for exactly the following cycle.
    - The address counter advances by ADDR_STEP.
    - o_word_count increments.
    - The byte counter wraps to 0.
  - The write is visible one cycle after the 4th byte strobe.
  - o_instruccion and o_address hold their values until the next write.
- HALT_WORD:
  - If the assembled word equals HALT_WORD, it is still written (o_wr_en pulse).
  - On the same edge, state -> DONE.
  - o_loading falls in the same cycle the halt word's o_wr_en is high.
- Overflow:
  - If a non-halt word is written while o_word_count==MEM_DEPTH-1, that word is written normally.
  - State -> OVERFLOW on the same edge.
  - Bytes received after that are never written.
- DONE:
  - o_done=1, o_loading=0, o_wr_en=0.
  - A CMD_LOAD byte -> LOAD: o_done clears, counters clear, new load starts at address 0.
  - Other bytes are ignored.
- OVERFLOW:
  - o_error=1, o_loading=0.
  - A CMD_LOAD byte -> LOAD and clears o_error.
  - Other bytes are ignored.
- Partial word: a partially assembled word (1-3 bytes) is not written unless completed. It is discarded on reset.
- Reset mid-load: all state is lost. The half-built word and counters clear, and o_loading drops on the next edge.
- Address arithmetic: DATA_WIDTH wide, unsigned. MEM_DEPTH*ADDR_STEP < 2^DATA_WIDTH, so no wrap occurs within a legal load.
- o_wr_en is never high outside the cycle following a 4th byte in LOAD.

Test Plan:
- Reset, then idle bytes 0x00, 0x41 -> state stays IDLE; all outputs 0.
- Send 0x4C, 0x20,0x01,0x00,0x05 (gaps of 0..7 idle cycles) -> o_loading=1; a single o_wr_en pulse one cycle after the last byte with o_instruccion=32'h2001_0005, o_address=0; o_word_count=1.
- Continue with 0x00,0x22,0x18,0x20 then FF,FF,FF,FF -> writes 32'h0022_1820 @4 and 32'hFFFF_FFFF @8; o_done=1, o_loading=0, o_word_count=3.
- MEM_DEPTH=4, send 'L' + 5 non-halt words -> 4 writes at 0,4,8,12; 5th word not written; o_error=1.
- Send 'L' + 2 bytes, assert i_reset one cycle -> all outputs 0, no o_wr_en. Then 'L' + 4 bytes -> write at address 0 with only the new bytes.
- From DONE send 'L' + 11223344 + halt -> o_done clears, then writes at 0 and 4; o_done=1, o_word_count=2.

Source files
------------

// File: rtl/instr_loader.sv
// instr_loader: assembles UART bytes MSB-first into instruction words and loads them into instruction memory.
module instr_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_STEP = 4,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [BYTE_WIDTH-1:0] CMD_LOAD = 8'h4C,
  localparam int WC_W = $clog2(MEM_DEPTH) + 1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [BYTE_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_done,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic                  o_wr_en,
  output logic                  o_loading,
  output logic                  o_done,
  output logic                  o_error,
  output logic [WC_W-1:0]       o_word_count
);
  typedef enum logic [1:0] {IDLE, LOAD, DONE, OVERFLOW} state_t;
  state_t r_state, w_next;
  logic [DATA_WIDTH-BYTE_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_addr, w_word;
  logic [1:0] r_byte_cnt;
  logic w_start, w_byte, w_last, w_halt, w_full;
  assign w_word = {r_shift, i_rx_data};
  // the load command only means something outside LOAD; inside LOAD it is plain data
  assign w_start = i_rx_done && i_rx_data == CMD_LOAD && r_state != LOAD;
  assign w_byte = i_rx_done && r_state == LOAD;
  assign w_last = w_byte && r_byte_cnt == 2'd3;
  assign w_halt = w_word == HALT_WORD;
  assign w_full = o_word_count == WC_W'(MEM_DEPTH - 1);
  assign o_loading = r_state == LOAD;
  assign o_done = r_state == DONE;
  assign o_error = r_state == OVERFLOW;
  always_comb begin
    w_next = r_state;
    w_next = w_start ? LOAD : !w_last ? r_state : w_halt ? DONE : w_full ? OVERFLOW : LOAD;
  end
  always_ff @(posedge i_clock) r_state <= i_reset ? IDLE : w_next;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_shift <= '0;
      r_addr <= '0;
      r_byte_cnt <= '0;
      o_instruccion <= '0;
      o_address <= '0;
      o_wr_en <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_wr_en <= w_last;
      if (w_start) begin
        r_shift <= '0;
        r_addr <= '0;
        r_byte_cnt <= '0;
        o_word_count <= '0;
      end else if (w_byte) begin
        r_shift <= w_word[DATA_WIDTH-BYTE_WIDTH-1:0];
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (w_last) begin
        o_instruccion <= w_word;
        o_address <= r_addr;
        r_addr <= r_addr + DATA_WIDTH'(ADDR_STEP);
        o_word_count <= o_word_count + WC_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed and random byte streams checked cycle by cycle against a queue-based loader model.
module tb_instr_loader;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b0, rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic [31:0] instr, addr;
  logic wr_en, loading, done, error;
  logic [2:0] wc;
  int n_tests = 0, n_fail = 0;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_OVF = 3;
  int mode = M_IDLE;
  logic [7:0] pend[$];
  logic [31:0] e_instr = 0, e_addr = 0, next_addr = 0, e_wc = 0;
  logic e_wr = 1'b0;

  instr_loader #(.MEM_DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .o_instruccion(instr), .o_address(addr), .o_wr_en(wr_en), .o_loading(loading),
    .o_done(done), .o_error(error), .o_word_count(wc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic d, input logic [7:0] b, input logic r);
    logic [31:0] w;
    e_wr = 1'b0;
    if (r) begin
      mode = M_IDLE;
      pend.delete();
      e_instr = 0; e_addr = 0; next_addr = 0; e_wc = 0;
    end else if (d && mode != M_LOAD) begin
      if (b == 8'h4C) begin
        mode = M_LOAD;
        pend.delete();
        next_addr = 0; e_wc = 0;
      end
    end else if (d) begin
      pend.push_back(b);
      if (pend.size() == 4) begin
        w = {pend[0], pend[1], pend[2], pend[3]};
        pend.delete();
        e_wr = 1'b1;
        e_instr = w;
        e_addr = next_addr;
        next_addr += 4;
        if (w == 32'hFFFF_FFFF) mode = M_DONE;
        else if (e_wc == DEPTH - 1) mode = M_OVF;
        e_wc++;
      end
    end
  endtask

  task automatic cycle(input logic d, input logic [7:0] b, input logic r);
    rx_done = d; rx_data = b; rst = r;
    model_step(d, b, r);
    @(posedge clk);
    #1;
    check("wr_en", 32'(wr_en), 32'(e_wr));
    check("instr", instr, e_instr);
    check("addr", addr, e_addr);
    check("loading", 32'(loading), 32'(mode == M_LOAD));
    check("done", 32'(done), 32'(mode == M_DONE));
    check("error", 32'(error), 32'(mode == M_OVF));
    check("word_count", 32'(wc), e_wc);
  endtask

  task automatic send(input logic [7:0] b);
    int g;
    g = $urandom_range(0, 7);
    for (int i = 0; i < g; i++) cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, b, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[i*8 +: 8]);
  endtask

  initial begin
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    send(8'h00); send(8'h41);
    cycle(1'b0, 8'h00, 1'b0);
    send(8'h4C);
    send_word(32'h2001_0005);
    cycle(1'b0, 8'h00, 1'b0);
    send_word(32'h0022_1820);
    send_word(32'hFFFF_FFFF);
    cycle(1'b0, 8'h00, 1'b0);
    send(8'h4C);
    for (int k = 0; k < 5; k++) send_word(32'h1000_0000 + 32'(k));
    cycle(1'b0, 8'h00, 1'b0);
    send(8'h4C); send(8'h12); send(8'h34);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    send(8'h4C);
    send_word(32'hA1B2_C3D4);
    send_word(32'hFFFF_FFFF);
    send(8'h4C);
    send_word(32'h1122_3344);
    send_word(32'hFFFF_FFFF);
    cycle(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 600; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) cycle(1'b0, 8'h00, 1'b1);
      else if (r < 10) send(8'h4C);
      else if (r < 14) send_word(32'hFFFF_FFFF);
      else if (r < 20) send(8'hFF);
      else send(8'($urandom));
    end
    cycle(1'b0, 8'h00, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
